// File: rtl/jpeg_image_buffer_pkg.sv
// jpeg_image_buffer_pkg: shared state encoding, buffer size default and word/byte helpers
package jpeg_image_buffer_pkg;
  localparam int BUF_BYTES_DEF = 16384;
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE, S_READ} state_e;
  typedef logic [7:0] byte_t;
  typedef logic [31:0] word_t;
  function automatic logic [15:0] byte_sum(input word_t w);
    return 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
  endfunction
endpackage

// File: rtl/jpeg_image_buffer_ram.sv
// jpeg_image_buffer_ram: single-port word RAM with registered read (no read while writing)
module jpeg_image_buffer_ram
  import jpeg_image_buffer_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);
  word_t mem_q [2**AW];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;
    else rdata_o <= mem_q[addr_i];
endmodule

// File: rtl/jpeg_image_buffer.sv
// jpeg_image_buffer: captures one encoded image into RAM and replays it as a valid/ready byte stream.
// Optional checksum_out port when JPEG_IMAGE_BUFFER_CHECKSUM_EN is defined.
module jpeg_image_buffer
  import jpeg_image_buffer_pkg::*;
#(
  parameter int BUF_BYTES = BUF_BYTES_DEF
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        start_capture_in,
  input  logic [31:0] data_in,
  input  logic [15:0] address_in,
  input  logic        data_valid_in,
  input  logic        image_valid_in,
  input  logic        rd_start_in,
  output logic [7:0]  rd_data_out,
  output logic        rd_valid_out,
  output logic        rd_last_out,
  input  logic        rd_ready_in,
  output logic        image_ready_out,
  output logic [15:0] image_size_out,
  output logic        overflow_out,
`ifdef JPEG_IMAGE_BUFFER_CHECKSUM_EN
  output logic        busy_out,
  output logic [15:0] checksum_out
`else
  output logic        busy_out
`endif
);
  localparam int AW = $clog2(BUF_BYTES);
  localparam int WAW = AW - 2;
  localparam logic [16:0] CAP = 17'(BUF_BYTES);
  state_e state_q;
  logic [15:0] size_q;
  logic overflow_q, rd_valid_q, pend_q, pf_valid_q;
  word_t out_q, pf_q, ram_rdata, next_word;
  logic [16:0] idx_q, fa_q, limit, nwords;
  logic cap_wr, in_range, we, rd_go, issue, fire, last_byte, need_word, have_word;
  logic [WAW-1:0] ram_addr;
  always_comb begin
    limit = ({1'b0, size_q} > CAP) ? CAP : {1'b0, size_q};
    nwords = (limit + 17'd3) >> 2;
    in_range = {1'b0, address_in} < CAP;
    cap_wr = data_valid_in & ~start_capture_in & ((state_q == S_CAPTURE) |
             ((state_q == S_ARMED) & (address_in == 16'd0) & ~image_valid_in));
    we = cap_wr & in_range;
    rd_go = (state_q == S_DONE) & rd_start_in & (size_q != 16'd0) & ~start_capture_in;
    issue = rd_go | ((state_q == S_READ) & ~pend_q & ~pf_valid_q & (fa_q < nwords));
    ram_addr = we ? address_in[AW-1:2] : (rd_go ? '0 : fa_q[WAW-1:0]);
    fire = rd_valid_q & rd_ready_in;
    last_byte = idx_q == limit - 17'd1;
    // a fresh word is needed when nothing is shown yet or the last byte of the current word leaves
    need_word = ~rd_valid_q | (fire & (idx_q[1:0] == 2'd3) & ~last_byte);
    have_word = pf_valid_q | pend_q;
    next_word = pf_valid_q ? pf_q : ram_rdata;
  end
  jpeg_image_buffer_ram #(.AW(WAW)) u_ram (
    .clk_i  (clock_in),
    .we_i   (we),
    .addr_i (ram_addr),
    .wdata_i(data_in),
    .rdata_o(ram_rdata)
  );
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) begin
      state_q <= S_IDLE;
      size_q <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      pend_q <= 1'b0;
      pf_valid_q <= 1'b0;
      out_q <= '0;
      pf_q <= '0;
      idx_q <= '0;
      fa_q <= '0;
    end else if (start_capture_in) begin
      state_q <= S_ARMED;
      size_q <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      pend_q <= 1'b0;
      pf_valid_q <= 1'b0;
    end else begin
      pend_q <= issue;
      if (cap_wr && !in_range) overflow_q <= 1'b1;
      if (issue) fa_q <= rd_go ? 17'd1 : fa_q + 17'd1;
      case (state_q)
        S_ARMED: if (cap_wr) state_q <= S_CAPTURE;
        S_CAPTURE: if (image_valid_in) begin
          state_q <= S_DONE;
          size_q <= address_in;
        end
        S_DONE: if (rd_go) begin
          state_q <= S_READ;
          idx_q <= '0;
        end
        S_READ: if (fire && last_byte) begin
          state_q <= S_DONE;
          rd_valid_q <= 1'b0;
          pf_valid_q <= 1'b0;
        end else begin
          if (fire) idx_q <= idx_q + 17'd1;
          if (need_word) begin
            rd_valid_q <= have_word;
            pf_valid_q <= 1'b0;
            if (have_word) out_q <= next_word;
          end else if (pend_q) begin
            pf_q <= ram_rdata;
            pf_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef JPEG_IMAGE_BUFFER_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) csum_q <= '0;
    else if (start_capture_in) csum_q <= '0;
    else if (we) csum_q <= csum_q + byte_sum(data_in);
  assign checksum_out = csum_q;
`endif
  assign rd_data_out = out_q[{idx_q[1:0], 3'b000} +: 8];
  assign rd_valid_out = rd_valid_q;
  assign rd_last_out = rd_valid_q & last_byte;
  assign image_ready_out = (state_q == S_DONE) | (state_q == S_READ);
  assign image_size_out = size_q;
  assign overflow_out = overflow_q;
  assign busy_out = (state_q == S_ARMED) | (state_q == S_CAPTURE) | (state_q == S_READ);
endmodule

// File: tb/tb_jpeg_image_buffer.sv
// tb_jpeg_image_buffer: directed capture/readout scenarios with a byte-addressed reference memory
module tb_jpeg_image_buffer;
  logic clk = 1'b0, rst = 1'b1, start_cap = 1'b0, dv = 1'b0, iv = 1'b0, rd_start = 1'b0, rd_ready = 1'b1;
  logic [31:0] data = '0;
  logic [15:0] addr = '0;
  logic [7:0] rd_data;
  logic rd_valid, rd_last, img_ready, ovf, busy;
  logic [15:0] img_size;
`ifdef JPEG_IMAGE_BUFFER_CHECKSUM_EN
  logic [15:0] csum;
`endif
  int checks = 0, errors = 0;
  logic [7:0] model [int];
  always #5 clk = ~clk;
  jpeg_image_buffer dut (
    .clock_in(clk), .reset_in(rst), .start_capture_in(start_cap), .data_in(data),
    .address_in(addr), .data_valid_in(dv), .image_valid_in(iv), .rd_start_in(rd_start),
    .rd_data_out(rd_data), .rd_valid_out(rd_valid), .rd_last_out(rd_last), .rd_ready_in(rd_ready),
    .image_ready_out(img_ready), .image_size_out(img_size), .overflow_out(ovf),
`ifdef JPEG_IMAGE_BUFFER_CHECKSUM_EN
    .busy_out(busy), .checksum_out(csum)
`else
    .busy_out(busy)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put_word(input logic [15:0] a, input logic [31:0] d, input bit upd);
    dv = 1'b1;
    addr = a;
    data = d;
    tick();
    dv = 1'b0;
    if (upd && a < 16384) for (int j = 0; j < 4; j++) model[int'(a) + j] = d[8*j +: 8];
  endtask
  task automatic pulse_start();
    start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
  endtask
  task automatic finish_image(input logic [15:0] sz);
    iv = 1'b1;
    addr = sz;
    tick();
  endtask
  task automatic read_image(input string tag, input int n, input int stall_pct);
    int got, cyc, first, nlast, last_pos, bad, hold_bad;
    logic [7:0] hd;
    logic hl;
    bit holding;
    got = 0; cyc = 1; first = -1; nlast = 0; last_pos = -1; bad = 0; hold_bad = 0; holding = 0;
    hd = '0; hl = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (got < n && cyc < 3 * n + 50) begin
      rd_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (rd_valid) begin
        if (first < 0) first = cyc;
        if (holding && (rd_data !== hd || rd_last !== hl)) hold_bad++;
        if (rd_ready) begin
          if (model.exists(got) && rd_data !== model[got]) bad++;
          if (rd_last) begin nlast++; last_pos = got; end
          got++;
          holding = 0;
        end else begin
          holding = 1; hd = rd_data; hl = rd_last;
        end
      end else if (holding) hold_bad++;
      tick();
      cyc++;
    end
    rd_ready = 1'b1;
    check({tag, "_first_latency"}, first, 2);
    check({tag, "_count"}, got, n);
    check({tag, "_last_pos"}, last_pos, n - 1);
    check({tag, "_last_count"}, nlast, 1);
    check({tag, "_bytes_bad"}, bad, 0);
    check({tag, "_stall_hold_bad"}, hold_bad, 0);
    @(negedge clk);
    check({tag, "_valid_after"}, rd_valid, 1'b0);
    check({tag, "_ready_after"}, {img_ready, busy}, 2'b10);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {rd_valid, rd_last, img_ready, ovf, busy}, 5'b0);
    check("reset_size", img_size, 16'd0);
    check("reset_rd_data", rd_data, 8'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    check("idle_rd_start_ignored", {rd_valid, busy}, 2'b00);
    pulse_start();
    check("armed_flags", {busy, img_ready}, 2'b10);
    for (int i = 0; i < 10; i++)
      put_word(16'(4 * i), {8'(28 * i + 24), 8'(28 * i + 17), 8'(28 * i + 10), 8'(28 * i + 3)}, 1);
    check("capture_busy", {busy, img_ready}, 2'b10);
    finish_image(16'd38);
    check("done_flags", {img_ready, busy, ovf}, 3'b100);
    check("done_size", img_size, 16'd38);
    read_image("rd38", 38, 0);
    read_image("rd38_stall", 38, 50);
    pulse_start();
    put_word(16'd0, 32'hCAFEF00D, 0);
    repeat (2) tick();
    check("stale_iv_stays_armed", {busy, img_ready}, 2'b10);
    iv = 1'b0;
    put_word(16'd0, 32'h55667788, 1);
    check("stale_capture_entered", {busy, img_ready}, 2'b10);
    finish_image(16'd0);
    check("zero_size_done", {img_ready, busy}, 2'b10);
    check("zero_size_value", img_size, 16'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    check("zero_size_rd_ignored", {rd_valid, busy, img_ready}, 3'b001);
    pulse_start();
    iv = 1'b0;
    put_word(16'd0, 32'h11223344, 1);
    put_word(16'd16380, 32'hDEADBEEF, 1);
    check("ovf_before_drop", ovf, 1'b0);
    put_word(16'd16384, 32'h99999999, 0);
    check("ovf_after_drop", ovf, 1'b1);
    finish_image(16'd16388);
    check("ovf_size_unclipped", img_size, 16'd16388);
    read_image("rd_full", 16384, 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (5) tick();
    check("abort_pre_valid", rd_valid, 1'b1);
    start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    @(negedge clk);
    check("abort_valid_drop", rd_valid, 1'b0);
    check("abort_flags", {busy, img_ready, ovf}, 3'b100);
    check("abort_size", img_size, 16'd0);
    iv = 1'b0;
    put_word(16'd0, 32'h04030201, 1);
    put_word(16'd4, 32'h000000FF, 1);
    finish_image(16'd8);
    check("csum_img_size", img_size, 16'd8);
`ifdef JPEG_IMAGE_BUFFER_CHECKSUM_EN
    check("checksum", csum, 16'h0109);
`endif
    read_image("rd8", 8, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
